// File: rtl/block_operand_sequencer.sv
// -----------------------------------------------------------------------------
// block_operand_sequencer
//
// Purpose:
//   Sequencer for the 4-operand async compute block. A handshaked nibble
//   stream is loaded into the operand slots in order (bk_in1..bk_in4). The
//   sequencer then waits a fixed settle time for the block output to become
//   valid, captures it, and offers it on a handshaked result port. Only one
//   run is in flight at a time.
//
// Configuration macro:
//   BLKSEQ_CHAIN_EN - when defined, each run after a completed result
//   handshake reuses the previous result as operand 1. Only three operands
//   (bk_in2..bk_in4) are then loaded. Reset or abort clears the chain, so the
//   next run loads all four operands again.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   ena_i        design enable; low freezes all state
//   abort_i      synchronous abort of the current run (highest priority)
//   in_data_i    operand nibble
//   in_valid_i   operand valid
//   in_ready_o   sequencer can accept an operand (combinational)
//   bk_in1_o..4  operand registers driving the block inputs
//   bk_out_i     block result (async; sampled only at capture)
//   res_data_o   captured result
//   res_valid_o  result valid
//   res_ready_i  consumer accepts the result
//   busy_o       high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module block_operand_sequencer #(
    parameter int DATA_W        = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ena_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] bk_in1_o,
    output logic [DATA_W-1:0] bk_in2_o,
    output logic [DATA_W-1:0] bk_in3_o,
    output logic [DATA_W-1:0] bk_in4_o,
    input  logic [DATA_W-1:0] bk_out_i,
    output logic [DATA_W-1:0] res_data_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RESULT = 2'd3
    } state_e;

    // The settle counter is loaded with SETTLE_CYCLES-1 so that capture
    // happens exactly SETTLE_CYCLES edges after the edge that loads operand 4.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [1:0]        slotIdx_q, slotIdx_d;
    logic [3:0]        settleCnt_q, settleCnt_d;
    logic [DATA_W-1:0] operand_q [4];
    logic [DATA_W-1:0] operand_d [4];
    logic [DATA_W-1:0] resData_q, resData_d;
    logic              resValid_q, resValid_d;
    logic              xfer;

`ifdef BLKSEQ_CHAIN_EN
    logic              chain_q, chain_d;
`endif

    // Operands are only accepted while idle or loading, and never while the
    // design is held in reset or disabled.
    assign in_ready_o = rst_ni & ena_i & ((state_q == IDLE) | (state_q == LOAD));
    assign xfer       = in_valid_i & in_ready_o;

    assign bk_in1_o    = operand_q[0];
    assign bk_in2_o    = operand_q[1];
    assign bk_in3_o    = operand_q[2];
    assign bk_in4_o    = operand_q[3];
    assign res_data_o  = resData_q;
    assign res_valid_o = resValid_q;
    assign busy_o      = (state_q != IDLE);

    // State register: everything clears on the asynchronous reset; otherwise
    // the next-state logic decides (it already holds values when ena_i is low).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            slotIdx_q   <= 2'd0;
            settleCnt_q <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                operand_q[i] <= '0;
            end
            resData_q   <= '0;
            resValid_q  <= 1'b0;
`ifdef BLKSEQ_CHAIN_EN
            chain_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            slotIdx_q   <= slotIdx_d;
            settleCnt_q <= settleCnt_d;
            for (int i = 0; i < 4; i++) begin
                operand_q[i] <= operand_d[i];
            end
            resData_q   <= resData_d;
            resValid_q  <= resValid_d;
`ifdef BLKSEQ_CHAIN_EN
            chain_q     <= chain_d;
`endif
        end
    end

    // Next-state logic. Abort wins over everything and drops any beat
    // presented in the same cycle. Operand registers are left untouched by
    // abort, so the block inputs stay stable.
    always_comb begin
        state_d     = state_q;
        slotIdx_d   = slotIdx_q;
        settleCnt_d = settleCnt_q;
        for (int i = 0; i < 4; i++) begin
            operand_d[i] = operand_q[i];
        end
        resData_d   = resData_q;
        resValid_d  = resValid_q;
`ifdef BLKSEQ_CHAIN_EN
        chain_d     = chain_q;
`endif

        if (ena_i) begin
            if (abort_i) begin
                state_d     = IDLE;
                slotIdx_d   = 2'd0;
                settleCnt_d = 4'd0;
                resValid_d  = 1'b0;
`ifdef BLKSEQ_CHAIN_EN
                chain_d     = 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (xfer) begin
                            operand_d[slotIdx_q] = in_data_i;
                            slotIdx_d            = slotIdx_q + 2'd1;
                            state_d              = LOAD;
                        end
                    end
                    LOAD: begin
                        if (xfer) begin
                            operand_d[slotIdx_q] = in_data_i;
                            if (slotIdx_q == 2'd3) begin
                                slotIdx_d   = 2'd0;
                                settleCnt_d = SETTLE_LOAD;
                                state_d     = SETTLE;
                            end else begin
                                slotIdx_d   = slotIdx_q + 2'd1;
                            end
                        end
                    end
                    SETTLE: begin
                        if (settleCnt_q == 4'd0) begin
                            resData_d  = bk_out_i;
                            resValid_d = 1'b1;
                            state_d    = RESULT;
`ifdef BLKSEQ_CHAIN_EN
                            if (chain_q) begin
                                operand_d[0] = bk_out_i;
                            end
`endif
                        end else begin
                            settleCnt_d = settleCnt_q - 4'd1;
                        end
                    end
                    RESULT: begin
                        if (res_ready_i) begin
                            resValid_d = 1'b0;
                            state_d    = IDLE;
`ifdef BLKSEQ_CHAIN_EN
                            // The handshake that starts a chain seeds operand 1
                            // with the result just delivered; later captures
                            // keep it updated directly from the block output.
                            if (!chain_q) begin
                                operand_d[0] = resData_q;
                            end
                            chain_d   = 1'b1;
                            slotIdx_d = 2'd1;
`endif
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_block_operand_sequencer.sv
// Testbench for block_operand_sequencer.
// The compute block is modelled as the 4-bit sum of its four operands.
// Results expected by each scenario are queued when the operands are driven;
// the monitor pops and compares them when a result handshake occurs.
module tb_block_operand_sequencer;

   logic       clk = 1'b0;
   logic       rstN;
   logic       ena;
   logic       abort;
   logic [3:0] inData;
   logic       inValid;
   logic       inReady;
   logic [3:0] bkIn1, bkIn2, bkIn3, bkIn4;
   logic [3:0] bkOut;
   logic [3:0] resData;
   logic       resValid;
   logic       resReady;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   logic [3:0] expRes[$];

   // 10 ns clock
   always #5 clk = ~clk;

   // Block model: sum of the four operands, wrapped to 4 bits
   assign bkOut = bkIn1 + bkIn2 + bkIn3 + bkIn4;

   block_operand_sequencer #(
       .DATA_W(4),
       .SETTLE_CYCLES(4)
   ) dut (
       .clk_i(clk),
       .rst_ni(rstN),
       .ena_i(ena),
       .abort_i(abort),
       .in_data_i(inData),
       .in_valid_i(inValid),
       .in_ready_o(inReady),
       .bk_in1_o(bkIn1),
       .bk_in2_o(bkIn2),
       .bk_in3_o(bkIn3),
       .bk_in4_o(bkIn4),
       .bk_out_i(bkOut),
       .res_data_o(resData),
       .res_valid_o(resValid),
       .res_ready_i(resReady),
       .busy_o(busy)
   );

   // Scoreboard monitor: a result handshake will happen on the coming rising
   // edge; compare the offered result against the oldest expected one.
   always @(negedge clk) begin
      #2;
      if (rstN && ena && !abort && resValid && resReady) begin
         checks++;
         if (expRes.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_result: got %h, required no result", resData);
         end else begin
            logic [3:0] exp;
            exp = expRes.pop_front();
            if (resData !== exp) begin
               errors++;
               $display("[TB] FAIL result_data: got %h, required %h", resData, exp);
            end
         end
      end
   end

   // Global watchdog so the run always terminates
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one beat after an idle gap; returns at the falling edge following
   // the accepting rising edge. A beat never accepted counts as a failure.
   task automatic sendBeat(input logic [3:0] d, input int gap);
      bit taken;
      taken = 1'b0;
      inValid = 1'b0;
      repeat (gap) @(negedge clk);
      inValid = 1'b1;
      inData  = d;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (inReady) begin
            @(posedge clk);
            taken = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      inValid = 1'b0;
      if (!taken) begin
         checks++;
         errors++;
         $display("[TB] FAIL beat_timeout: beat %h accepted 0, required 1", d);
      end
   endtask

   // Count falling edges until res_valid is seen; -1 when it never comes
   task automatic waitValid(output int cycles);
      cycles = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (resValid) begin
            cycles = k;
            break;
         end
      end
   endtask

   // One-cycle abort to start a scenario from a clean, unchained idle state
   task automatic abortPulse();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rstN = 1'b0; ena = 1'b1; abort = 1'b0;
      inData = 4'h0; inValid = 1'b0; resReady = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bkIn1, bkIn2, bkIn3, bkIn4, resData, resValid, busy, inReady} !== 23'd0) begin
         errors++;
         $display("[TB] FAIL reset_state: got %h, required 0",
                  {bkIn1, bkIn2, bkIn3, bkIn4, resData, resValid, busy, inReady});
      end
      rstN = 1'b1;
      @(negedge clk);
      checks++;
      if (inReady !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: got ready=%b busy=%b, required ready=1 busy=0",
                  inReady, busy);
      end
   endtask

   task automatic test_basic();
      int lat;
      abortPulse();
      resReady = 1'b1;
      expRes.push_back(4'hA);
      sendBeat(4'h1, 0); sendBeat(4'h2, 0); sendBeat(4'h3, 0); sendBeat(4'h4, 0);
      checks++;
      if ({bkIn1, bkIn2, bkIn3, bkIn4} !== 16'h1234) begin
         errors++;
         $display("[TB] FAIL basic_operands: got %h, required 1234", {bkIn1, bkIn2, bkIn3, bkIn4});
      end
      waitValid(lat);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("[TB] FAIL basic_latency: got %0d, required 4", lat);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || resValid !== 1'b0 || expRes.size() != 0) begin
         errors++;
         $display("[TB] FAIL basic_return_idle: got busy=%b valid=%b pending=%0d, required 0 0 0",
                  busy, resValid, expRes.size());
      end
   endtask

   task automatic test_backpressure();
      int lat;
      abortPulse();
      resReady = 1'b0;
      expRes.push_back(4'hA);
      sendBeat(4'h1, 0); sendBeat(4'h2, 0); sendBeat(4'h3, 0); sendBeat(4'h4, 0);
      waitValid(lat);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("[TB] FAIL bp_latency: got %0d, required 4", lat);
      end
      inValid = 1'b1;
      inData  = 4'h7;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (resValid !== 1'b1 || resData !== 4'hA || inReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold: cycle %0d got valid=%b data=%h ready=%b, required 1 a 0",
                     c, resValid, resData, inReady);
         end
      end
      inValid = 1'b0;
      checks++;
      if ({bkIn1, bkIn2, bkIn3, bkIn4} !== 16'h1234) begin
         errors++;
         $display("[TB] FAIL bp_operands: got %h, required 1234", {bkIn1, bkIn2, bkIn3, bkIn4});
      end
      @(negedge clk);
      resReady = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || expRes.size() != 0) begin
         errors++;
         $display("[TB] FAIL bp_drain: got busy=%b pending=%0d, required 0 0", busy, expRes.size());
      end
   endtask

   task automatic test_gaps();
      int lat;
      logic [3:0] beats [4];
      beats[0] = 4'h3; beats[1] = 4'h0; beats[2] = 4'h5; beats[3] = 4'hF;
      abortPulse();
      resReady = 1'b1;
      expRes.push_back(4'h7);
      for (int b = 0; b < 4; b++) begin
         sendBeat(beats[b], int'($urandom_range(0, 3)));
      end
      waitValid(lat);
      checks++;
      if (lat !== 4 || {bkIn1, bkIn2, bkIn3, bkIn4} !== 16'h305F) begin
         errors++;
         $display("[TB] FAIL gaps_run: got lat=%0d ops=%h, required lat=4 ops=305f",
                  lat, {bkIn1, bkIn2, bkIn3, bkIn4});
      end
      repeat (2) @(negedge clk);
      checks++;
      if (expRes.size() != 0) begin
         errors++;
         $display("[TB] FAIL gaps_drain: got pending=%0d, required 0", expRes.size());
      end
   endtask

   task automatic test_abort();
      int lat;
      abortPulse();
      resReady = 1'b1;
      sendBeat(4'h1, 0); sendBeat(4'h2, 0);
      abort   = 1'b1;
      inValid = 1'b1;
      inData  = 4'h9;
      @(negedge clk);
      abort   = 1'b0;
      inValid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || {bkIn1, bkIn2, bkIn3, bkIn4} !== 16'h125F) begin
         errors++;
         $display("[TB] FAIL abort_state: got busy=%b ops=%h, required busy=0 ops=125f",
                  busy, {bkIn1, bkIn2, bkIn3, bkIn4});
      end
      expRes.push_back(4'h0);
      sendBeat(4'h8, 0); sendBeat(4'h8, 0); sendBeat(4'h8, 0); sendBeat(4'h8, 0);
      waitValid(lat);
      checks++;
      if (lat !== 4 || {bkIn1, bkIn2, bkIn3, bkIn4} !== 16'h8888) begin
         errors++;
         $display("[TB] FAIL abort_rerun: got lat=%0d ops=%h, required lat=4 ops=8888",
                  lat, {bkIn1, bkIn2, bkIn3, bkIn4});
      end
      repeat (4) @(negedge clk);
      checks++;
      if (expRes.size() != 0 || resValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_drain: got pending=%0d valid=%b, required 0 0",
                  expRes.size(), resValid);
      end
   endtask

   task automatic test_async_reset();
      abortPulse();
      resReady = 1'b1;
      expRes.push_back(4'hA);
      sendBeat(4'h1, 0); sendBeat(4'h2, 0); sendBeat(4'h3, 0); sendBeat(4'h4, 0);
      @(negedge clk);
      #3;
      rstN = 1'b0;
      #1;
      checks++;
      if ({bkIn1, bkIn2, bkIn3, bkIn4, resData, resValid, busy, inReady} !== 23'd0) begin
         errors++;
         $display("[TB] FAIL async_reset: got %h, required 0",
                  {bkIn1, bkIn2, bkIn3, bkIn4, resData, resValid, busy, inReady});
      end
      expRes.delete();
      @(negedge clk);
      rstN = 1'b1;
      repeat (8) @(negedge clk);
      checks++;
      if (resValid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset_idle: got valid=%b busy=%b, required 0 0", resValid, busy);
      end
   endtask

   task automatic test_enable_freeze();
      int lat;
      abortPulse();
      resReady = 1'b1;
      expRes.push_back(4'hA);
      sendBeat(4'h1, 0); sendBeat(4'h2, 0); sendBeat(4'h3, 0); sendBeat(4'h4, 0);
      @(negedge clk);
      ena = 1'b0;
      repeat (3) @(negedge clk);
      ena = 1'b1;
      waitValid(lat);
      checks++;
      if (lat !== 3) begin
         errors++;
         $display("[TB] FAIL ena_freeze_latency: got %0d, required %0d", lat + 4, 7);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (expRes.size() != 0) begin
         errors++;
         $display("[TB] FAIL ena_drain: got pending=%0d, required 0", expRes.size());
      end
   endtask

`ifdef BLKSEQ_CHAIN_EN
   task automatic test_chain();
      int lat;
      abortPulse();
      resReady = 1'b1;
      expRes.push_back(4'hA);
      sendBeat(4'h1, 0); sendBeat(4'h2, 0); sendBeat(4'h3, 0); sendBeat(4'h4, 0);
      waitValid(lat);
      repeat (2) @(negedge clk);
      checks++;
      if (bkIn1 !== 4'hA) begin
         errors++;
         $display("[TB] FAIL chain_seed: got %h, required a", bkIn1);
      end
      expRes.push_back(4'hD);
      sendBeat(4'h1, 0); sendBeat(4'h1, 0); sendBeat(4'h1, 0);
      checks++;
      if ({bkIn1, bkIn2, bkIn3, bkIn4} !== 16'hA111) begin
         errors++;
         $display("[TB] FAIL chain_operands: got %h, required a111", {bkIn1, bkIn2, bkIn3, bkIn4});
      end
      waitValid(lat);
      checks++;
      if (lat !== 4 || bkIn1 !== 4'hD) begin
         errors++;
         $display("[TB] FAIL chain_capture: got lat=%0d in1=%h, required lat=4 in1=d", lat, bkIn1);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (expRes.size() != 0) begin
         errors++;
         $display("[TB] FAIL chain_drain: got pending=%0d, required 0", expRes.size());
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_gaps();
      test_abort();
      test_async_reset();
      test_enable_freeze();
`ifdef BLKSEQ_CHAIN_EN
      test_chain();
`endif
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
